// File: rtl/fifo_pkg.sv
// Shared definitions for the byte-FIFO read-side word packer.
package fifo_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int PACK_DEF       = 4;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_EMIT  = 2'd2
    } state_e;

    // Lanes 0..n-1 set; callers truncate to their lane count.
    function automatic logic [31:0] keep_mask(input int unsigned n);
        logic [31:0] m;
        m = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < n) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/fifo_word_packer.sv
// Drains the byte FIFO (1-cycle read latency) and packs PACK entries into one
// little-endian word on a valid/ready stream; flush emits a partial word.
module fifo_word_packer
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int PACK       = PACK_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       fifo_empty,
    input  logic [DATA_WIDTH-1:0]      fifo_data,
    output logic                       fifo_rd_en,
    output logic [DATA_WIDTH*PACK-1:0] m_data,
    output logic [PACK-1:0]            m_keep,
    output logic                       m_valid,
    input  logic                       m_ready,
    input  logic                       flush,
    output logic                       flush_done
);

    localparam int              IW   = $clog2(PACK) + 1;
    localparam logic [IW-1:0]   FULL = IW'(PACK);

    state_e                         state, state_nxt;
    logic [PACK-1:0][DATA_WIDTH-1:0] asm_q, asm_nxt, asm_part, out_q;
    logic [PACK-1:0]                keep_q, keep_part;
    logic [IW-1:0]                  idx, cnt_nxt;
    logic                           rd_pending, valid_q, flush_word, done_q;
    logic                           slot_free, hs, load_full, load_part;

    assign m_data    = out_q;
    assign m_keep    = keep_q;
    assign m_valid   = valid_q;
    assign slot_free = !valid_q || m_ready;
    assign hs        = valid_q && m_ready;
    assign keep_part = PACK'(keep_mask(32'(idx)));

    // Lane capture; a word completes on the same edge as its last capture.
    always_comb begin
        asm_nxt = asm_q;
        cnt_nxt = idx;
        if (rd_pending) begin
            asm_nxt[idx[IW-2:0]] = fifo_data;
            cnt_nxt              = idx + IW'(1);
        end
    end

    always_comb begin
        for (int i = 0; i < PACK; i++)
            asm_part[i] = keep_part[i] ? asm_q[i] : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ST_RUN;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:   if (flush) state_nxt = ST_DRAIN;
            ST_DRAIN: if (!rd_pending) state_nxt = (idx != '0) ? ST_EMIT : ST_RUN;
            ST_EMIT:  if (hs && flush_word) state_nxt = ST_RUN;
            default:  state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        fifo_rd_en = 1'b0;
        load_full  = 1'b0;
        load_part  = 1'b0;
        flush_done = 1'b0;
        if (!reset) begin
            flush_done = done_q;
            case (state)
                ST_RUN: begin
                    fifo_rd_en = !fifo_empty && ((idx + IW'(rd_pending)) < FULL);
                    load_full  = (cnt_nxt == FULL) && slot_free;
                end
                ST_EMIT: begin
                    load_part  = !flush_word && slot_free;
                    flush_done = flush_word && hs;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx        <= '0;
            rd_pending <= 1'b0;
            asm_q      <= '0;
            out_q      <= '0;
            keep_q     <= '0;
            valid_q    <= 1'b0;
            flush_word <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            rd_pending <= fifo_rd_en;
            done_q     <= (state == ST_DRAIN) && !rd_pending && (idx == '0);
            if (hs) begin
                valid_q    <= 1'b0;
                flush_word <= 1'b0;
            end
            if (load_full) begin
                out_q   <= asm_nxt;
                keep_q  <= '1;
                valid_q <= 1'b1;
                idx     <= '0;
            end else if (load_part) begin
                out_q      <= asm_part;
                keep_q     <= keep_part;
                valid_q    <= 1'b1;
                flush_word <= 1'b1;
                idx        <= '0;
            end else begin
                asm_q <= asm_nxt;
                idx   <= cnt_nxt;
            end
        end
    end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer (PACK=4, DATA_WIDTH=8) with a small
// registered-read FIFO model in front of it.
module tb_fifo_word_packer;

    logic        clk = 1'b0;
    logic        reset, fifo_empty, fifo_rd_en, m_valid, m_ready, flush, flush_done;
    logic [7:0]  fifo_data;
    logic [31:0] m_data;
    logic [3:0]  m_keep;

    always #5 clk = ~clk;

    fifo_word_packer #(.DATA_WIDTH(8), .PACK(4)) dut (
        .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_rd_en(fifo_rd_en), .m_data(m_data), .m_keep(m_keep), .m_valid(m_valid),
        .m_ready(m_ready), .flush(flush), .flush_done(flush_done)
    );

    // FIFO model: data_out registered one cycle after Read_enable.
    logic [7:0] mem [0:63];
    logic [5:0] wp, rp;
    logic       push_en, hold;
    logic [7:0] push_byte;

    assign fifo_empty = hold || (wp == rp);

    always @(posedge clk) begin
        if (reset) begin
            wp <= '0; rp <= '0; fifo_data <= '0;
        end else begin
            if (fifo_rd_en && (wp != rp)) begin
                fifo_data <= mem[rp];
                rp        <= rp + 6'd1;
            end
            if (push_en) begin
                mem[wp] <= push_byte;
                wp      <= wp + 6'd1;
            end
        end
    end

    // Monitor: accepted beats, read-issue log, output stability.
    typedef struct packed { logic [31:0] d; logic [3:0] k; logic fd; } beat_t;
    beat_t       got[$];
    int          rd_log[$];
    int          cyc = 0, bad_rd = 0, stable_err = 0;
    logic        held_v = 1'b0;
    logic [31:0] held_d = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        beat_t b;
        #1;
        if (!reset) begin
            if (fifo_rd_en) begin
                rd_log.push_back(cyc);
                if (int'(dut.idx) + int'(dut.rd_pending) >= 4) bad_rd++;
            end
            if (m_valid && m_ready) begin
                b.d = m_data; b.k = m_keep; b.fd = flush_done;
                got.push_back(b);
            end
            if (held_v && (m_data != held_d)) stable_err++;
            held_v = m_valid && !m_ready;
            held_d = m_data;
        end else begin
            held_v = 1'b0;
        end
    end

    int applied = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        push_en   = 1'b1;
        push_byte = b;
        @(negedge clk);
        push_en   = 1'b0;
    endtask

    task automatic wait_beats(input int n);
        int k = 0;
        while (got.size() < n && k < 80) begin
            @(negedge clk); #2;
            k++;
        end
    endtask

    typedef struct {
        int          n;
        logic [31:0] din;
        logic        do_flush;
        logic [31:0] exp_data;
        logic [3:0]  exp_keep;
        logic        exp_done;
    } vec_t;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        vt[6];
        int          gb, rb, lb;
        logic [31:0] w;
        logic [3:0]  pat;

        vt[0] = '{4, 32'h44332211, 1'b0, 32'h44332211, 4'hF,    1'b0};
        vt[1] = '{4, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 4'hF,    1'b0};
        vt[2] = '{3, 32'h00CCBBAA, 1'b1, 32'h00CCBBAA, 4'b0111, 1'b1};
        vt[3] = '{1, 32'h0000005A, 1'b1, 32'h0000005A, 4'b0001, 1'b1};
        vt[4] = '{2, 32'h0000A55A, 1'b1, 32'h0000A55A, 4'b0011, 1'b1};
        vt[5] = '{4, 32'h80FF0001, 1'b0, 32'h80FF0001, 4'hF,    1'b0};

        reset = 1'b1; m_ready = 1'b1; flush = 1'b0;
        push_en = 1'b0; push_byte = '0; hold = 1'b0;

        // Reset with FIFO empty
        repeat (3) @(negedge clk);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_keep", m_keep, 0);
        chk("rst_flush_done", flush_done, 0);
        chk("rst_rd_en", fifo_rd_en, 0);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        chk("idle_reads", rd_log.size(), 0);
        chk("idle_m_valid", m_valid, 0);

        // Table: fill n lanes, flush partial words, compare the accepted beat
        for (int v = 0; v < 6; v++) begin
            gb = got.size();
            rb = rd_log.size();
            hold = 1'b1;
            for (int i = 0; i < vt[v].n; i++) begin
                w = vt[v].din >> (8 * i);
                push(w[7:0]);
            end
            hold = 1'b0;
            repeat (8) @(negedge clk);
            if (vt[v].do_flush) begin
                flush = 1'b1;
                @(negedge clk);
                flush = 1'b0;
            end
            wait_beats(gb + 1);
            repeat (3) @(negedge clk);
            chk($sformatf("v%0d_beats", v), got.size() - gb, 1);
            if (got.size() > gb) begin
                chk($sformatf("v%0d_data", v), got[gb].d, vt[v].exp_data);
                chk($sformatf("v%0d_keep", v), {28'd0, got[gb].k}, {28'd0, vt[v].exp_keep});
                chk($sformatf("v%0d_done", v), got[gb].fd, vt[v].exp_done);
            end
            chk($sformatf("v%0d_reads", v), rd_log.size() - rb, vt[v].n);
        end

        // Back-to-back 8 bytes: one stall per word
        gb = got.size(); rb = rd_log.size(); lb = bad_rd;
        hold = 1'b1;
        for (int i = 1; i <= 8; i++) push(8'(i));
        hold = 1'b0;
        wait_beats(gb + 2);
        repeat (3) @(negedge clk);
        chk("b2b_beats", got.size() - gb, 2);
        if (got.size() >= gb + 2) begin
            chk("b2b_word0", got[gb].d, 32'h04030201);
            chk("b2b_word1", got[gb+1].d, 32'h08070605);
        end
        chk("b2b_reads", rd_log.size() - rb, 8);
        if (rd_log.size() >= rb + 8)
            chk("b2b_span", rd_log[rb+7] - rd_log[rb] + 2, 10);
        chk("b2b_no_read_at_full", bad_rd - lb, 0);

        // Backpressure: 12 bytes with m_ready low
        gb = got.size(); rb = rd_log.size(); lb = stable_err;
        m_ready = 1'b0;
        hold = 1'b1;
        for (int i = 0; i < 12; i++) push(8'(8'h10 + i));
        hold = 1'b0;
        repeat (30) @(negedge clk);
        chk("bp_m_valid", m_valid, 1);
        chk("bp_m_data", m_data, 32'h13121110);
        chk("bp_idx_full", dut.idx, 4);
        chk("bp_fifo_left", 32'(wp - rp), 4);
        chk("bp_rd_en", fifo_rd_en, 0);
        chk("bp_reads", rd_log.size() - rb, 8);
        m_ready = 1'b1;
        wait_beats(gb + 3);
        repeat (4) @(negedge clk);
        chk("bp_beats", got.size() - gb, 3);
        if (got.size() >= gb + 3) begin
            chk("bp_word0", got[gb].d, 32'h13121110);
            chk("bp_word1", got[gb+1].d, 32'h17161514);
            chk("bp_word2", got[gb+2].d, 32'h1B1A1918);
        end
        chk("bp_stable", stable_err - lb, 0);

        // Flush with nothing assembled: done two cycles later, no word
        gb = got.size();
        pat = '0;
        flush = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            flush = 1'b0;
            #2;
            pat[k-1] = flush_done;
        end
        chk("flush0_done_pattern", {28'd0, pat}, 32'h2);
        chk("flush0_no_word", got.size() - gb, 0);

        // Reset with a partial word in the assembly register
        hold = 1'b1;
        push(8'hE1); push(8'hE2);
        hold = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_idx_before_reset", dut.idx, 2);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_rd_en", fifo_rd_en, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_idx_after_reset", dut.idx, 0);
        chk("mid_m_valid", m_valid, 0);
        chk("mid_m_data", m_data, 0);
        gb = got.size();
        hold = 1'b1;
        push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
        hold = 1'b0;
        wait_beats(gb + 1);
        repeat (6) @(negedge clk);
        chk("mid_beats", got.size() - gb, 1);
        if (got.size() > gb) begin
            chk("mid_word", got[gb].d, 32'hC4C3C2C1);
            chk("mid_keep", {28'd0, got[gb].k}, 32'hF);
        end

        $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
        $finish;
    end

endmodule

// File: doc/fifo_word_packer.md
# fifo_word_packer

Read-side consumer for the byte FIFO. It drains the FIFO through its `Read_enable`/`empty`/`data_out` port, which has one-cycle registered read latency. It packs `PACK` consecutive entries into one little-endian wide word and presents that word on a valid/ready stream to the next stage. A flush request emits a partial word with a lane-keep mask.

## Interface
- `DATA_WIDTH`, default 8: width of one FIFO entry (lane).
- `PACK`, default 4: lanes per output word; power of two, ≥2.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high; shared with the FIFO.
- `fifo_empty`  in  1  FIFO `empty` flag.
- `fifo_data`  in  DATA_WIDTH  FIFO `data_out`; valid the cycle after a read is issued.
- `fifo_rd_en`  out  1  drives FIFO `Read_enable`; combinational.
- `m_data`  out  DATA_WIDTH*PACK  packed word; lane 0 (first entry read) is in bits [DATA_WIDTH-1:0].
- `m_keep`  out  PACK  per-lane valid mask.
- `m_valid`  out  1  word available.
- `m_ready`  in  1  downstream accepts the word.
- `flush`  in  1  single-cycle request to emit the partial word.
- `flush_done`  out  1  one-cycle pulse when the flush completes.

## Operation
- State registers:
  - `idx`: lanes filled, 0..PACK, width clog2(PACK)+1.
  - `rd_pending`: a read was issued last cycle.
  - Assembly register `asm`.
  - Output register.
  - FSM state.
- FSM states and transitions:
  - RUN: normal operation.
  - RUN → DRAIN on `flush`.
  - DRAIN: no new reads; wait until `rd_pending` is 0.
  - DRAIN → EMIT if `idx` > 0. Otherwise DRAIN → RUN, pulsing `flush_done`.
  - EMIT: move `asm` to the output once the output slot is free. `m_keep` = lanes 0..idx-1 set; unused lanes of `m_data` are zero.
  - EMIT → RUN on the word's handshake (`m_valid && m_ready`), pulsing `flush_done` that cycle.
- Read issue rule: `fifo_rd_en` = RUN && !`fifo_empty` && (`idx` + `rd_pending` < PACK).
- Capture: when `rd_pending` is 1, `fifo_data` is written to lane `idx` and `idx` increments.
- Word transfer:
  - Occurs when `idx`==PACK and the output slot is free (!`m_valid` || `m_ready`).
  - The output register is loaded, `m_keep` = all ones, and `idx` is cleared in the same edge.
  - If the slot is not free, `asm` holds and `idx` stays at PACK, which stalls reads.
- Output hold: `m_data`/`m_keep` are stable while `m_valid` && !`m_ready`. `m_valid` clears on handshake unless a new word loads in the same edge.
- `flush` outside RUN is ignored. `flush` in the same cycle as a read issue is legal: that read completes in DRAIN.
- Reset: values, clearing and FIFO pairing are defined in Timing.

## Timing
- Reset values: `fifo_rd_en`=0, `m_valid`=0, `m_data`=0, `m_keep`=0, `flush_done`=0, `idx`=0, `rd_pending`=0, FSM=RUN.
- Reset has priority over all other activity. An in-flight read byte is discarded and the partial word is lost. The FIFO is reset in the same cycle, so no data skew occurs.
- Read latency: data issued at cycle N is captured at the N+1 edge.
- Word latency: the earliest `m_valid` is the cycle after the last lane's capture edge.
- Throughput: per word, reads stall for one cycle when `idx` + `rd_pending` == PACK. Sustained rate is PACK entries per PACK+1 cycles with `m_ready`=1.
- Backpressure: the output and a full `asm` give two words of buffering; reads stop after that.
- `flush_done` pulses once per accepted flush. It never coincides with `m_valid` of a full word issued after the flush.

## Structure
- Shared package `fifo_pkg`:
  - DATA_WIDTH/PACK defaults.
  - FSM state enum (RUN, DRAIN, EMIT).
  - `keep_mask(idx)` function.
- Single module; no sub-module is natural. Lane write and output register are small enough to inline.

## Test plan
All scenarios use PACK=4 and DATA_WIDTH=8.
- Reset with the FIFO empty → all outputs 0; `fifo_rd_en` never asserts.
- Push 11,22,33,44 with `m_ready`=1 → one beat, `m_data`=0x44332211, `m_keep`=4'hF; `fifo_rd_en` high for exactly 4 cycles.
- Push 01..08 back-to-back with `m_ready`=1 → words 0x04030201 then 0x08070605. `fifo_rd_en` is never high when `idx`+`rd_pending`==4; there are 10 cycles from the first read to the last capture.
- Push 12 bytes with `m_ready`=0 → word 1 is held stable, `asm` is full, reads stop, and the FIFO keeps 4 entries. Raise `m_ready` → three words are emitted in order with no loss or duplication.
- Push AA,BB,CC, then pulse `flush` → `m_data`=0x00CCBBAA, `m_keep`=4'b0111, and `flush_done` pulses on the handshake. A `flush` with `idx`=0 → `flush_done` 2 cycles later and no `m_valid`.
- Consume 2 bytes, then assert `reset` for 1 cycle → `idx`=0 and outputs are 0. Then push 4 fresh bytes → one clean full word with no stale lanes.
